// File: rtl/dram_arbiter.sv
// Two-requester arbiter for the single-port data RAM: registered issue onto the
// RAM strobes and fixed-latency routing of read data back to the issuing requester.
module dram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  logic              elig0_s;
  logic              elig1_s;
  logic              win0_s;
  logic              win1_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              ptr_r;
  logic [RD_LAT-1:0] tag_vld_r;
  logic [RD_LAT-1:0] tag_id_r;

  // Winner selection; a requester whose grant is currently high is not eligible
  always_comb begin
    elig0_s = req0 & ~gnt0;
    elig1_s = req1 & ~gnt1;
    win0_s  = 1'b0;
    win1_s  = 1'b0;
    if (elig0_s && elig1_s) begin
      if ((PRIO_MODE == 1) || (ptr_r == 1'b0)) begin
        win0_s = 1'b1;
      end else begin
        win1_s = 1'b1;
      end
    end else begin
      win0_s = elig0_s;
      win1_s = elig1_s;
    end
    if (win1_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Issue stage: grants and RAM strobes are registered for the issue cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_din   <= {DATA_W{1'b0}};
      ptr_r     <= 1'b0;
    end else begin
      gnt0 <= win0_s;
      gnt1 <= win1_s;
      if (win0_s || win1_s) begin
        mem_addr  <= sel_addr_s;
        mem_write <= sel_we_s;
        mem_read  <= ~sel_we_s;
        if (sel_we_s) begin
          mem_din <= sel_wdata_s;
        end
      end else begin
        mem_write <= 1'b0;
        mem_read  <= 1'b0;
      end
      // Pointer only moves on a contended round-robin decision
      if ((PRIO_MODE == 0) && elig0_s && elig1_s) begin
        ptr_r <= ~ptr_r;
      end
    end
  end

  // Read return: tag shift register tracks each issued read until its data arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= {RD_LAT{1'b0}};
      tag_id_r  <= {RD_LAT{1'b0}};
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= {DATA_W{1'b0}};
      rdata1    <= {DATA_W{1'b0}};
    end else begin
      tag_vld_r[0] <= mem_read;
      tag_id_r[0]  <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
      end
      rvalid0 <= tag_vld_r[RD_LAT-1] & ~tag_id_r[RD_LAT-1];
      rvalid1 <= tag_vld_r[RD_LAT-1] &  tag_id_r[RD_LAT-1];
      if (tag_vld_r[RD_LAT-1] && !tag_id_r[RD_LAT-1]) begin
        rdata0 <= mem_dout;
      end
      if (tag_vld_r[RD_LAT-1] && tag_id_r[RD_LAT-1]) begin
        rdata1 <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: a round-robin instance (RD_LAT=2) and a fixed-priority
// instance (RD_LAT=1) share requester stimulus; each has its own RAM and reference model.
`timescale 1ns/1ps
module tb_dram_arbiter;

  localparam int LAT_RR = 2;
  localparam int LAT_FP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;

  logic [1:0]  g0, g1, mw, mr, rv0, rv1;
  logic [15:0] maddr [2];
  logic [7:0]  mdin [2];
  logic [7:0]  rd0 [2];
  logic [7:0]  rd1 [2];
  logic [7:0]  mdout [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(LAT_RR), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(g0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(g1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
    .mem_addr(maddr[0]), .mem_write(mw[0]), .mem_read(mr[0]),
    .mem_din(mdin[0]), .mem_dout(mdout[0]));

  dram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(LAT_FP), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(g0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(g1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
    .mem_addr(maddr[1]), .mem_write(mw[1]), .mem_read(mr[1]),
    .mem_din(mdin[1]), .mem_dout(mdout[1]));

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_RR : LAT_FP;
  endfunction

  // RAM environment: writes land at the end of the issue cycle, reads return after the latency
  logic [7:0] ram [2][65536];
  logic [7:0] rr_p0, rr_p1, fp_p0;
  assign mdout[0] = rr_p1;
  assign mdout[1] = fp_p0;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[0][a] <= pat(a[15:0]);
      ram[1][a] <= pat(a[15:0]);
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) if (mw[k]) ram[k][maddr[k]] <= mdin[k];
      if (mr[0]) rr_p0 <= ram[0][maddr[0]];
      rr_p1 <= rr_p0;
      if (mr[1]) fp_p0 <= ram[1][maddr[1]];
    end
  end

  // Reference model: grant order, shadow memory contents and due cycle of every read return
  typedef struct {int k; int due; bit id; logic [7:0] data;} ret_t;
  ret_t retq[$];
  logic [7:0]  shadow [2][65536];
  bit          m_g0 [2], m_g1 [2], m_wr [2], m_rd [2], m_rv0 [2], m_rv1 [2], m_ptr [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_din [2], m_rdata0 [2], m_rdata1 [2];

  task automatic model_step();
    bit e0, e1, we_w;
    int w;
    logic [15:0] a_w;
    logic [7:0] d_w;
    ret_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_rv0[k] = 1'b0;
      m_rv1[k] = 1'b0;
      if (rst) begin
        m_g0[k] = 1'b0; m_g1[k] = 1'b0; m_wr[k] = 1'b0; m_rd[k] = 1'b0; m_ptr[k] = 1'b0;
        m_addr[k] = 16'h0000; m_din[k] = 8'h00; m_rdata0[k] = 8'h00; m_rdata1[k] = 8'h00;
        for (int q = retq.size() - 1; q >= 0; q--) if (retq[q].k == k) retq.delete(q);
      end else begin
        e0 = req0 && !m_g0[k];
        e1 = req1 && !m_g1[k];
        w = -1;
        if (e0 && e1) begin
          if (k == 1) w = 0;
          else begin w = int'(m_ptr[k]); m_ptr[k] = !m_ptr[k]; end
        end else if (e0) w = 0;
        else if (e1) w = 1;
        we_w = (w == 1) ? we1 : we0;
        a_w  = (w == 1) ? addr1 : addr0;
        d_w  = (w == 1) ? wdata1 : wdata0;
        m_g0[k] = (w == 0);
        m_g1[k] = (w == 1);
        m_wr[k] = (w >= 0) && we_w;
        m_rd[k] = (w >= 0) && !we_w;
        if (w >= 0) begin
          m_addr[k] = a_w;
          if (we_w) begin
            m_din[k] = d_w;
            shadow[k][a_w] = d_w;
          end else begin
            e.k = k; e.due = cyc + lat_of(k) + 1; e.id = (w == 1); e.data = shadow[k][a_w];
            retq.push_back(e);
          end
        end
        for (int q = retq.size() - 1; q >= 0; q--) begin
          if (retq[q].k == k && retq[q].due == cyc) begin
            if (retq[q].id) begin m_rv1[k] = 1'b1; m_rdata1[k] = retq[q].data; end
            else begin m_rv0[k] = 1'b1; m_rdata0[k] = retq[q].data; end
            retq.delete(q);
          end
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      shadow[0][a] = pat(a[15:0]);
      shadow[1][a] = pat(a[15:0]);
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0005; addr1 = 16'h0006; wdata0 = 8'h00; wdata1 = 8'h00;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({g0[k], g1[k], mw[k], mr[k], rv0[k], rv1[k]} !== 6'b000000 || maddr[k] !== 16'h0000 ||
            mdin[k] !== 8'h00 || rd0[k] !== 8'h00 || rd1[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_outputs inst=%0d got gnt=%b%b wr=%b rd=%b rv=%b%b addr=%h din=%h required all zero",
                   k, g0[k], g1[k], mw[k], mr[k], rv0[k], rv1[k], maddr[k], mdin[k]);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g0[k] !== 1'b1 || g1[k] !== 1'b0 || mr[k] !== 1'b1 || maddr[k] !== 16'h0005) begin
        errors++;
        $display("FAIL first_grant inst=%0d got gnt0=%b gnt1=%b rd=%b addr=%h required gnt0=1 gnt1=0 rd=1 addr=0005",
                 k, g0[k], g1[k], mr[k], maddr[k]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(6);
  endtask

  task automatic test_single_rw();
    int t_g;
    int t_v [2];
    t_v[0] = -100; t_v[1] = -100;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 8'hA5;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g0[k] !== 1'b1 || mw[k] !== 1'b1 || mr[k] !== 1'b0 || maddr[k] !== 16'h0010 || mdin[k] !== 8'hA5) begin
        errors++;
        $display("FAIL write_issue inst=%0d got gnt0=%b wr=%b rd=%b addr=%h din=%h required 1 1 0 0010 a5",
                 k, g0[k], mw[k], mr[k], maddr[k], mdin[k]);
      end
    end
    we0 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g0[k] !== 1'b0 || mw[k] !== 1'b0 || mr[k] !== 1'b0) begin
        errors++;
        $display("FAIL no_double_grant inst=%0d got gnt0=%b wr=%b rd=%b required 0 0 0", k, g0[k], mw[k], mr[k]);
      end
    end
    @(negedge clk);
    t_g = cyc;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g0[k] !== 1'b1 || mr[k] !== 1'b1 || maddr[k] !== 16'h0010) begin
        errors++;
        $display("FAIL read_issue inst=%0d got gnt0=%b rd=%b addr=%h required 1 1 0010", k, g0[k], mr[k], maddr[k]);
      end
    end
    req0 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rv0[k] === 1'b1) begin
          t_v[k] = cyc;
          checks++;
          if (rd0[k] !== 8'hA5) begin
            errors++;
            $display("FAIL read_data inst=%0d got rdata0=%h required a5", k, rd0[k]);
          end
        end
        checks++;
        if (rv1[k] !== 1'b0) begin
          errors++;
          $display("FAIL rvalid1_quiet inst=%0d got rvalid1=%b required 0", k, rv1[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (t_v[k] - t_g != lat_of(k) + 1) begin
        errors++;
        $display("FAIL read_latency inst=%0d got %0d cycles required %0d", k, t_v[k] - t_g, lat_of(k) + 1);
      end
    end
  endtask

  task automatic test_round_robin();
    int prev = -1;
    int n_g0 = 0, n_g1 = 0, n_v0 = 0, n_v1 = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0001;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n < 8) begin
        checks++;
        if (g0[0] === g1[0] || mr[0] !== 1'b1 || int'(g1[0]) == prev || g0[0] !== m_g0[0]) begin
          errors++;
          $display("FAIL rr_alternate cycle=%0d got gnt0=%b gnt1=%b rd=%b required alternating single grant (model gnt0=%b) with rd=1",
                   n, g0[0], g1[0], mr[0], m_g0[0]);
        end
        prev = int'(g1[0]);
        n_g0 += int'(g0[0]);
        n_g1 += int'(g1[0]);
      end
      if (rv0[0] === 1'b1) begin
        n_v0++;
        checks++;
        if (rd0[0] !== 8'h5A) begin
          errors++;
          $display("FAIL rr_data0 got %h required 5a", rd0[0]);
        end
      end
      if (rv1[0] === 1'b1) begin
        n_v1++;
        checks++;
        if (rd1[0] !== 8'h5B) begin
          errors++;
          $display("FAIL rr_data1 got %h required 5b", rd1[0]);
        end
      end
      if (n == 7) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (n_v0 != n_g0 || n_v1 != n_g1 || n_g0 != 4) begin
      errors++;
      $display("FAIL rr_counts got grants %0d/%0d returns %0d/%0d required 4/4 grants each returned", n_g0, n_g1, n_v0, n_v1);
    end
  endtask

  task automatic test_fixed_priority();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0001;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n < 6) begin
        checks++;
        if (g0[1] !== ((n % 2) == 0) || g1[1] !== ((n % 2) == 1) || mr[1] !== 1'b1) begin
          errors++;
          $display("FAIL fp_grant cycle=%0d got gnt0=%b gnt1=%b rd=%b required gnt0=%0d gnt1=%0d rd=1",
                   n, g0[1], g1[1], mr[1], (n % 2) == 0, (n % 2) == 1);
        end
      end
      if (rv0[1] === 1'b1 || rv1[1] === 1'b1) begin
        checks++;
        if ((rv0[1] === 1'b1 && rd0[1] !== 8'h5A) || (rv1[1] === 1'b1 && rd1[1] !== 8'h5B)) begin
          errors++;
          $display("FAIL fp_data got rdata0=%h rdata1=%h required 5a/5b", rd0[1], rd1[1]);
        end
      end
      if (n == 5) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_write_read_order();
    bit seen [2];
    seen[0] = 1'b0; seen[1] = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hFFFF; wdata1 = 8'h3C;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g1[k] !== 1'b1 || mw[k] !== 1'b1 || maddr[k] !== 16'hFFFF || mdin[k] !== 8'h3C) begin
        errors++;
        $display("FAIL top_write inst=%0d got gnt1=%b wr=%b addr=%h din=%h required 1 1 ffff 3c", k, g1[k], mw[k], maddr[k], mdin[k]);
      end
    end
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'hFFFF;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g0[k] !== 1'b1 || mr[k] !== 1'b1 || maddr[k] !== 16'hFFFF) begin
        errors++;
        $display("FAIL top_read inst=%0d got gnt0=%b rd=%b addr=%h required 1 1 ffff", k, g0[k], mr[k], maddr[k]);
      end
    end
    req0 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rv0[k] === 1'b1) begin
          seen[k] = 1'b1;
          checks++;
          if (rd0[k] !== 8'h3C) begin
            errors++;
            $display("FAIL write_then_read inst=%0d got rdata0=%h required 3c", k, rd0[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (!seen[k]) begin
        errors++;
        $display("FAIL top_read_return inst=%0d got no rvalid0 required one within 6 cycles", k);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (g1[k] !== 1'b1 || mr[k] !== 1'b1) begin
        errors++;
        $display("FAIL mid_read_issue inst=%0d got gnt1=%b rd=%b required 1 1", k, g1[k], mr[k]);
      end
    end
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({g0[k], g1[k], mw[k], mr[k], rv0[k], rv1[k]} !== 6'b000000 || maddr[k] !== 16'h0000 ||
            mdin[k] !== 8'h00 || rd0[k] !== 8'h00 || rd1[k] !== 8'h00) begin
          errors++;
          $display("FAIL reset_mid_read inst=%0d cycle=%0d got gnt=%b%b wr=%b rd=%b rv=%b%b addr=%h rdata=%h/%h required all zero",
                   k, n, g0[k], g1[k], mw[k], mr[k], rv0[k], rv1[k], maddr[k], rd0[k], rd1[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [45:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        got = {g0[k], g1[k], mw[k], mr[k], maddr[k], mdin[k], rv0[k], rv1[k], rd0[k], rd1[k]};
        exp = {m_g0[k], m_g1[k], m_wr[k], m_rd[k], m_addr[k], m_din[k], m_rv0[k], m_rv1[k], m_rdata0[k], m_rdata1[k]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_cycle inst=%0d cyc=%0d got %h required %h (gnt0,gnt1,wr,rd,addr,din,rv0,rv1,rdata0,rdata1)",
                   k, cyc, got, exp);
        end
      end
      rst = (n == 250);
      if (!req0 || g0[0]) begin
        req0   = ($urandom_range(0, 3) != 0);
        we0    = $urandom_range(0, 1) == 1;
        addr0  = ($urandom_range(0, 1) == 1 ? 16'hFFF8 : 16'h0000) | 16'($urandom_range(0, 7));
        wdata0 = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req0 = 1'b0;
      end
      if (!req1 || g1[0]) begin
        req1   = ($urandom_range(0, 3) != 0);
        we1    = $urandom_range(0, 1) == 1;
        addr1  = ($urandom_range(0, 1) == 1 ? 16'hFFF8 : 16'h0000) | 16'($urandom_range(0, 7));
        wdata1 = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    tick(6);
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_round_robin();
    test_fixed_priority();
    test_write_read_order();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port 64K x 8 data RAM between two requesters: requester 0 (processor datapath) and requester 1 (image load/unload engine).
- Accepts per-requester read/write requests through a req/gnt handshake and serialises them onto the RAM's address/din/write/read inputs.
- Routes returned read data back to the issuing requester with a fixed, parameterised latency.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, pixel/data width.
- RD_LAT, 1, cycles from the cycle mem_read is high to the cycle mem_dout is valid (1..4).
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (requester 0 always wins).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request; held with its fields until gnt0 is seen.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 address.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  one-cycle pulse: the request sampled at the previous edge is issued this cycle.
- rvalid0  out  1  one-cycle pulse: rdata0 holds read data for requester 0.
- rdata0  out  DATA_W  read data for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above, for requester 1.
- mem_addr  out  ADDR_W  RAM address.
- mem_write  out  1  RAM write strobe.
- mem_read  out  1  RAM read strobe.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data.

Behaviour:
- Reset (synchronous, rst high at a posedge):
  - gnt0/1, rvalid0/1, mem_write, mem_read = 0.
  - mem_addr, mem_din, rdata0/1 = 0.
  - Round-robin pointer = requester 0 preferred.
  - Read-tag pipeline cleared.
  - A read issued before reset never produces an rvalid.
- Eligibility at each posedge: requester i is eligible when req_i = 1 and gnt_i is not currently high. This prevents a double grant of a request that is being dropped on the same edge. Each requester therefore gets at most one grant per 2 cycles, and the memory can still be busy every cycle when the two requesters alternate.
- Winner selection:
  - None eligible: mem_write = mem_read = 0, no gnt.
  - One eligible: that requester wins.
  - Both eligible, PRIO_MODE = 0: the pointer's preferred requester wins, and the pointer then prefers the other requester.
  - Both eligible, PRIO_MODE = 1: requester 0 wins, and the pointer is unused.
- Issue (registered):
  - On the winning edge, mem_addr <= addr_w, mem_din <= wdata_w, mem_write <= we_w, mem_read <= ~we_w, gnt_w <= 1.
  - All of these are valid during the single following cycle, the issue cycle.
  - Latency from req sampled to RAM access is one cycle.
- Requester rule: after seeing gnt_i high, the requester may drop req_i or present a new request at that edge. That new request is eligible at the next edge.
- mem_din holds its last value when no write is issued. mem_addr updates only on issue.
- Read return:
  - A RD_LAT-deep shift register carries {valid, requester id} for each issued read.
  - RAM data is valid RD_LAT cycles after the issue cycle, and is captured into rdata_id at the edge ending that cycle.
  - rvalid_id is high for the cycle after that edge, so rvalid trails gnt by RD_LAT+1 cycles.
  - rdata_i holds its value until the next read return for requester i.
  - Writes produce no rvalid.
- Ordering:
  - Accesses reach the RAM in grant order.
  - A read issued after a write to the same address returns the new data, because the RAM writes on the issue cycle.
- Simultaneous return and issue: an rvalid for one requester and a gnt for either requester may coincide. There are no stalls.
- req dropped before grant: the request is withdrawn, no access is made, and there is no error.

Test Plan:
- Reset: drive rst = 1 for 2 cycles while req0 = req1 = 1 -> no gnt, no mem strobes. Release rst -> the first grant goes to requester 0.
- Single write/read: req0 write addr = 16'h0010, wdata = 8'hA5, then read addr = 16'h0010 -> mem_write one cycle after sampling; later rvalid0 with rdata0 = 8'hA5 exactly RD_LAT+1 cycles after its gnt0; rvalid1 stays 0.
- Round-robin contention: PRIO_MODE = 0, both requesters hold continuous reads (addr0 = 16'h0000, addr1 = 16'h0001) -> grant sequence 0,1,0,1 on consecutive cycles; mem_read high every cycle; each rvalid carries its own address's data.
- Fixed priority: PRIO_MODE = 1, both hold requests for 6 cycles -> gnt0 on alternate cycles; gnt1 only in the cycles where requester 0 is ineligible (its gnt0 is high).
- Write-then-read ordering: requester 1 writes 16'hFFFF = 8'h3C while requester 0 reads 16'hFFFF on the next grant -> rdata0 = 8'h3C; top-address boundary exercised.
- Reset mid-read: issue a read via req1 and assert rst in the cycle after gnt1 -> rvalid1 never pulses; all outputs return to 0.
